usbh_report_decoder_multi: RTL and testbench
============================================

Name: usbh_report_decoder_multi

Overview:
Parametrised successor of the single-pad USB HID joystick decoder. It converts raw HID reports from the USB host core into 8-bit NES button states for up to C_PLAYERS pads, demultiplexed by a report-ID byte. It adds a selectable D-pad source (hat or analog axes), an N-report glitch filter against spurious keypresses, a per-player report watchdog, a hold-timed menu combo and shared-phase autofire. It sits between the USB host (same clock domain) and the NES controller-port shifters.

Parameters:
C_CLK_HZ, 6000000, i_clk frequency in Hz
C_AUTOFIRE_HZ, 10, autofire toggle rate
C_REPORT_BITS, 64, width of i_report
C_PLAYERS, 2, pad count, 1..4
C_ID_LSB, 0, LSB of the 8-bit report-ID field; unused when C_PLAYERS=1
C_ID_BASE, 1, report-ID value for player 0
C_DPAD_MODE, 0, 0 = 4-bit hat, 1 = two 8-bit analog axes
C_HAT_LSB, 40, LSB of the 4-bit hat field
C_AXIS_X_LSB, 8, LSB of the X axis byte
C_AXIS_Y_LSB, 16, LSB of the Y axis byte
C_BTN_LSB, 44, LSB of the 11-bit raw button field, in order coin, play1, play2, red1..red4, blue1..blue4
C_FILTER_N, 2, consecutive identical decodes required to accept a state, 1..15
C_TIMEOUT_MS, 100, report-silence limit per player
C_MENU_HOLD_MS, 500, all-red hold time that activates menu

Ports:
i_clk  in  1  USB core clock
i_reset  in  1  asynchronous, active-high reset
i_report  in  C_REPORT_BITS  raw HID report
i_report_valid  in  1  one-cycle strobe; i_report is valid while it is high
o_btn  out  8*C_PLAYERS  per player {R,L,D,U,start,select,B,A}; player p at [8p+7:8p]
o_menu  out  C_PLAYERS  level, menu combo active
o_timeout  out  C_PLAYERS  level, no report within C_TIMEOUT_MS

Behaviour:
- Reset (async, active-high): o_btn=0, o_menu=0, o_timeout=all 1, all counters 0, filter candidates 0.
- Player select: p = ID - C_ID_BASE. A report whose p is outside 0..C_PLAYERS-1 is ignored completely; it touches no state. With C_PLAYERS=1, p=0 always.
- D-pad decode, hat mode: 0 U, 1 U+R, 2 R, 3 D+R, 4 D, 5 D+L, 6 L, 7 U+L, 8..15 none.
- D-pad decode, axis mode: L when X[7:6]=00, R when X[7:6]=11; U when Y[7:6]=00, D when Y[7:6]=11.
- Button mapping: A = blue1|blue3; B = blue2|blue4; turboA = red1|red3; turboB = red2|red4; start = play1; select = play2. The decoded 10-bit state is {udlr, start, select, B, A, turboB, turboA}.
- Glitch filter, per player: registers cand and cnt (4 bits). On a valid report for p:
  - if decode == cand: cnt saturates at C_FILTER_N;
  - else: cand <= decode, cnt <= 1.
  - In the cycle cnt reaches C_FILTER_N (including C_FILTER_N=1 on the first report), the accepted state is loaded from cand.
- Latency: with C_FILTER_N=1, o_btn reflects a report at T+2, where T is the i_report_valid cycle.
- Autofire: one free-running counter shared by all players, MSB period ≈ C_CLK_HZ/C_AUTOFIRE_HZ. o_btn A = accA | (turboA & MSB); o_btn B likewise.
- Menu, per player: a hold counter runs while the accepted red1..red4 are all 1, clears otherwise, and saturates at C_MENU_HOLD_MS*C_CLK_HZ/1000. At saturation o_menu[p]=1 and o_btn U, D, L, R are forced to 1. Both drop the cycle after the combo releases.
- Watchdog, per player: the counter clears on a valid report for p. On reaching C_TIMEOUT_MS*C_CLK_HZ/1000 it sets o_timeout[p]=1 and clears the accepted state, cand, cnt and the menu counter, so o_btn[p] reads 0 next cycle. The first valid report for p clears o_timeout[p] in the next cycle.
- Simultaneous valid report and timeout terminal count: the report wins; the counter clears and no flush occurs.
- Reports for one player never alter another player's state.
- All counters saturate; none wrap, except the autofire counter.

Test Plan:
- Reset mid-report with i_reset high → o_btn=0, o_timeout=all 1 immediately; after release, ID=1 report with hat=2, C_FILTER_N=2, two identical reports → o_btn[7:0]=8'h80 (R) after the second report +2 cycles.
- C_FILTER_N=2: report hat=0, then hat=4, then hat=4 → U never appears; D (8'h20) appears after the third report.
- Two players: ID=1 blue1, ID=2 play1 → o_btn[7:0]=8'h01, o_btn[15:8]=8'h08. ID=3 report → no change.
- Autofire: held red1 → bit0 toggles with period C_CLK_HZ/C_AUTOFIRE_HZ (use a scaled C_CLK_HZ in sim). blue1+red1 → bit0 steady 1.
- Menu: all reds held, reports every 1 ms → o_menu[0] rises exactly at the hold threshold with o_btn[7:4]=4'hF. Release one red → both clear next cycle.
- Watchdog: stop reports → o_timeout[0]=1 and o_btn[7:0]=0 at terminal count. Report arriving on the terminal cycle → no flush.

Source files
------------

// File: rtl/usbh_report_decoder_multi.sv
// HID report to NES button decoder for up to four pads: report-ID demux, hat/axis D-pad,
// N-report glitch filter, per-pad watchdog, hold-timed menu combo and shared autofire.
module usbh_report_decoder_multi #(
  parameter int C_CLK_HZ       = 6000000,
  parameter int C_AUTOFIRE_HZ  = 10,
  parameter int C_REPORT_BITS  = 64,
  parameter int C_PLAYERS      = 2,
  parameter int C_ID_LSB       = 0,
  parameter int C_ID_BASE      = 1,
  parameter int C_DPAD_MODE    = 0,
  parameter int C_HAT_LSB      = 40,
  parameter int C_AXIS_X_LSB   = 8,
  parameter int C_AXIS_Y_LSB   = 16,
  parameter int C_BTN_LSB      = 44,
  parameter int C_FILTER_N     = 2,
  parameter int C_TIMEOUT_MS   = 100,
  parameter int C_MENU_HOLD_MS = 500
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [C_REPORT_BITS-1:0] i_report,
  input  logic                     i_report_valid,
  output logic [8*C_PLAYERS-1:0]   o_btn,
  output logic [C_PLAYERS-1:0]     o_menu,
  output logic [C_PLAYERS-1:0]     o_timeout
);
  localparam longint TO_TERM_L   = longint'(C_TIMEOUT_MS) * longint'(C_CLK_HZ) / 1000;
  localparam longint MENU_TERM_L = longint'(C_MENU_HOLD_MS) * longint'(C_CLK_HZ) / 1000;
  localparam int TO_TERM   = (TO_TERM_L < 1) ? 1 : int'(TO_TERM_L);
  localparam int MENU_TERM = (MENU_TERM_L < 1) ? 1 : int'(MENU_TERM_L);
  localparam int TO_W      = $clog2(TO_TERM + 1);
  localparam int MENU_W    = $clog2(MENU_TERM + 1);
  localparam int AF_HALF_R = C_CLK_HZ / (2 * C_AUTOFIRE_HZ);
  localparam int AF_HALF   = (AF_HALF_R < 1) ? 1 : AF_HALF_R;
  localparam int AF_W      = $clog2(AF_HALF + 1);
  localparam logic [3:0] FILT_N = 4'(C_FILTER_N);

  // i_report_valid is a one-cycle strobe with no back-pressure: every strobed report is consumed.
  // Decoded state: {all_red, U, D, L, R, start, select, B, A, turboB, turboA}.
  logic [3:0]           hat;
  logic [7:0]           ax_x, ax_y, rep_id, rep_p;
  logic [10:0]          raw_btn, dec;
  logic                 u, d, l, r;
  logic [C_PLAYERS-1:0] hit;

  always_comb begin
    hat     = i_report[C_HAT_LSB +: 4];
    ax_x    = i_report[C_AXIS_X_LSB +: 8];
    ax_y    = i_report[C_AXIS_Y_LSB +: 8];
    raw_btn = i_report[C_BTN_LSB +: 11];
    rep_id  = i_report[C_ID_LSB +: 8];
    rep_p   = rep_id - 8'(C_ID_BASE);
    u = 1'b0; d = 1'b0; l = 1'b0; r = 1'b0;
    if (C_DPAD_MODE == 0) begin
      case (hat)
        4'd0: u = 1'b1;
        4'd1: begin u = 1'b1; r = 1'b1; end
        4'd2: r = 1'b1;
        4'd3: begin d = 1'b1; r = 1'b1; end
        4'd4: d = 1'b1;
        4'd5: begin d = 1'b1; l = 1'b1; end
        4'd6: l = 1'b1;
        4'd7: begin u = 1'b1; l = 1'b1; end
        default: ;
      endcase
    end else begin
      l = (ax_x[7:6] == 2'b00);
      r = (ax_x[7:6] == 2'b11);
      u = (ax_y[7:6] == 2'b00);
      d = (ax_y[7:6] == 2'b11);
    end
    dec = {&raw_btn[6:3], u, d, l, r, raw_btn[1], raw_btn[2],
           raw_btn[8] | raw_btn[10], raw_btn[7] | raw_btn[9],
           raw_btn[4] | raw_btn[6], raw_btn[3] | raw_btn[5]};
    for (int p = 0; p < C_PLAYERS; p++)
      hit[p] = i_report_valid && ((C_PLAYERS == 1) || (rep_p == 8'(p)));
  end

  logic [10:0]          stg_dec_q;
  logic [C_PLAYERS-1:0] stg_hit_q;
  logic [AF_W-1:0]      af_cnt_q;
  logic                 af_ph_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stg_dec_q <= '0;
      stg_hit_q <= '0;
      af_cnt_q  <= '0;
      af_ph_q   <= 1'b0;
    end else begin
      stg_dec_q <= dec;
      stg_hit_q <= hit;
      if (af_cnt_q == AF_W'(AF_HALF - 1)) begin
        af_cnt_q <= '0;
        af_ph_q  <= ~af_ph_q;
      end else begin
        af_cnt_q <= af_cnt_q + 1'b1;
      end
    end
  end

  for (genvar p = 0; p < C_PLAYERS; p++) begin : g_pl
    logic [10:0]       cand_q, cand_d, acc_q, acc_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [TO_W-1:0]   wd_q, wd_d;
    logic [MENU_W-1:0] menu_q, menu_d;
    logic              to_q, to_d, flush, menu_on;

    // Watchdog runs on the raw strobe so a report on the terminal cycle beats the flush.
    always_comb begin
      wd_d  = wd_q;
      to_d  = to_q;
      flush = 1'b0;
      if (hit[p]) begin
        wd_d = '0;
        to_d = 1'b0;
      end else if (wd_q != TO_W'(TO_TERM)) begin
        wd_d = wd_q + 1'b1;
        if (wd_q == TO_W'(TO_TERM - 1)) begin
          to_d  = 1'b1;
          flush = 1'b1;
        end
      end
      cand_d = cand_q;
      cnt_d  = cnt_q;
      acc_d  = acc_q;
      menu_d = '0;
      if (acc_q[10]) menu_d = menu_on ? menu_q : menu_q + 1'b1;
      if (flush) begin
        cand_d = '0;
        cnt_d  = '0;
        acc_d  = '0;
        menu_d = '0;
      end else if (stg_hit_q[p]) begin
        if (stg_dec_q == cand_q) begin
          cnt_d = (cnt_q >= FILT_N) ? FILT_N : cnt_q + 4'd1;
        end else begin
          cand_d = stg_dec_q;
          cnt_d  = 4'd1;
        end
        if (cnt_d == FILT_N) acc_d = stg_dec_q;
      end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        cand_q <= '0;
        acc_q  <= '0;
        cnt_q  <= '0;
        wd_q   <= '0;
        menu_q <= '0;
        to_q   <= 1'b1;
      end else begin
        cand_q <= cand_d;
        acc_q  <= acc_d;
        cnt_q  <= cnt_d;
        wd_q   <= wd_d;
        menu_q <= menu_d;
        to_q   <= to_d;
      end
    end

    assign menu_on      = (menu_q == MENU_W'(MENU_TERM));
    assign o_menu[p]    = menu_on;
    assign o_timeout[p] = to_q;
    assign o_btn[8*p +: 8] = {acc_q[6] | menu_on, acc_q[7] | menu_on,
                              acc_q[8] | menu_on, acc_q[9] | menu_on,
                              acc_q[5], acc_q[4],
                              acc_q[3] | (acc_q[1] & af_ph_q),
                              acc_q[2] | (acc_q[0] & af_ph_q)};
  end

endmodule

// File: tb/tb_usbh_report_decoder_multi.sv
// Directed bench for usbh_report_decoder_multi: vector table plus multi-cycle sequences
// (filter, reset, autofire, menu, watchdog) and a single-pad axis-mode instance.
module tb_usbh_report_decoder_multi;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] report = '0, report2 = '0;
  logic        valid = 1'b0, valid2 = 1'b0;
  logic [15:0] o_btn;
  logic [1:0]  o_menu, o_timeout;
  logic [7:0]  ax_btn;
  logic        ax_menu, ax_timeout;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  usbh_report_decoder_multi #(
    .C_CLK_HZ(10000), .C_AUTOFIRE_HZ(500), .C_PLAYERS(2), .C_FILTER_N(2),
    .C_TIMEOUT_MS(20), .C_MENU_HOLD_MS(5)
  ) u_dut (
    .i_clk(clk), .i_reset(reset), .i_report(report), .i_report_valid(valid),
    .o_btn(o_btn), .o_menu(o_menu), .o_timeout(o_timeout)
  );

  usbh_report_decoder_multi #(
    .C_CLK_HZ(10000), .C_AUTOFIRE_HZ(500), .C_PLAYERS(1), .C_DPAD_MODE(1),
    .C_FILTER_N(1), .C_TIMEOUT_MS(20), .C_MENU_HOLD_MS(5)
  ) u_ax (
    .i_clk(clk), .i_reset(reset), .i_report(report2), .i_report_valid(valid2),
    .o_btn(ax_btn), .o_menu(ax_menu), .o_timeout(ax_timeout)
  );

  typedef struct {
    logic [7:0]  id;
    logic [3:0]  hat;
    logic [10:0] btn;
    logic [7:0]  exp_lo;
    logic [7:0]  exp_hi;
  } vec_t;
  vec_t vecs[12];

  function automatic logic [63:0] mk(input logic [7:0] id, input logic [3:0] hat,
                                     input logic [10:0] btn, input logic [7:0] x,
                                     input logic [7:0] y);
    logic [63:0] v;
    v = '0;
    v[7:0]   = id;
    v[15:8]  = x;
    v[23:16] = y;
    v[43:40] = hat;
    v[54:44] = btn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [7:0] id, input logic [3:0] hat, input logic [10:0] btn);
    @(negedge clk);
    report = mk(id, hat, btn, 8'h80, 8'h80);
    valid  = 1'b1;
    @(negedge clk);
    valid  = 1'b0;
  endtask

  task automatic send_ax(input logic [7:0] x, input logic [7:0] y, input logic [10:0] btn);
    @(negedge clk);
    report2 = mk(8'h00, 4'd8, btn, x, y);
    valid2  = 1'b1;
    @(negedge clk);
    valid2  = 1'b0;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int prev, last, n_edge, steady;
    vecs[0]  = '{8'd1, 4'd2,  11'h000, 8'h80, 8'h00};
    vecs[1]  = '{8'd1, 4'd8,  11'h080, 8'h01, 8'h00};
    vecs[2]  = '{8'd2, 4'd8,  11'h002, 8'h01, 8'h08};
    vecs[3]  = '{8'd3, 4'd0,  11'h7FF, 8'h01, 8'h08};
    vecs[4]  = '{8'd0, 4'd4,  11'h000, 8'h01, 8'h08};
    vecs[5]  = '{8'd2, 4'd5,  11'h104, 8'h01, 8'h66};
    vecs[6]  = '{8'd1, 4'd1,  11'h600, 8'h93, 8'h66};
    vecs[7]  = '{8'd1, 4'd7,  11'h006, 8'h5C, 8'h66};
    vecs[8]  = '{8'd1, 4'd3,  11'h000, 8'hA0, 8'h66};
    vecs[9]  = '{8'd2, 4'd6,  11'h001, 8'hA0, 8'h40};
    vecs[10] = '{8'd1, 4'd15, 11'h000, 8'h00, 8'h40};
    vecs[11] = '{8'd2, 4'd0,  11'h000, 8'h00, 8'h10};

    // reset state
    wait_n(3);
    chk("rst_btn", 32'(o_btn), 32'h0);
    chk("rst_timeout", 32'(o_timeout), 32'h3);
    chk("rst_menu", 32'(o_menu), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // axis instance: filter of one, visible two cycles after the strobe
    send_ax(8'h00, 8'hFF, 11'h000);
    chk("ax_lat_early", 32'(ax_btn), 32'h00);
    wait_n(1);
    chk("ax_ld", 32'(ax_btn), 32'h60);
    send_ax(8'hFF, 8'h00, 11'h000);
    chk("ax_lat_early2", 32'(ax_btn), 32'h60);
    wait_n(1);
    chk("ax_ru", 32'(ax_btn), 32'h90);
    send_ax(8'h80, 8'h80, 11'h100);
    wait_n(1);
    chk("ax_b", 32'(ax_btn), 32'h02);
    send_ax(8'h40, 8'hC0, 11'h000);
    wait_n(1);
    chk("ax_d", 32'(ax_btn), 32'h20);

    // table: each vector sent twice to pass the two-report filter
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].id, vecs[i].hat, vecs[i].btn);
      send(vecs[i].id, vecs[i].hat, vecs[i].btn);
      wait_n(1);
      chk($sformatf("vec%0d_p0", i), 32'(o_btn[7:0]), 32'(vecs[i].exp_lo));
      chk($sformatf("vec%0d_p1", i), 32'(o_btn[15:8]), 32'(vecs[i].exp_hi));
    end
    chk("tbl_timeout", 32'(o_timeout), 32'h0);

    // glitch filter: a lone U report never reaches the output
    send(1, 4'd8, 11'h000);
    send(1, 4'd8, 11'h000);
    send(1, 4'd0, 11'h000);
    wait_n(2);
    chk("filt_no_u", 32'(o_btn[7:0]), 32'h00);
    send(1, 4'd4, 11'h000);
    wait_n(2);
    chk("filt_d_once", 32'(o_btn[7:0]), 32'h00);
    send(1, 4'd4, 11'h000);
    wait_n(1);
    chk("filt_d", 32'(o_btn[7:0]), 32'h20);

    // reset asserted in the middle of a report strobe
    @(negedge clk);
    report = mk(1, 4'd2, 11'h000, 8'h80, 8'h80);
    valid  = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("midrst_btn", 32'(o_btn), 32'h0);
    chk("midrst_timeout", 32'(o_timeout), 32'h3);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    send(1, 4'd2, 11'h000);
    wait_n(1);
    chk("post_rst_first", 32'(o_btn[7:0]), 32'h00);
    send(1, 4'd2, 11'h000);
    wait_n(1);
    chk("post_rst_r", 32'(o_btn[7:0]), 32'h80);

    // autofire: red1 alone toggles A every 10 cycles
    send(1, 4'd8, 11'h008);
    send(1, 4'd8, 11'h008);
    wait_n(1);
    prev = int'(o_btn[0]);
    last = -1;
    n_edge = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (int'(o_btn[0]) != prev) begin
        if (last >= 0) chk("af_half_period", 32'(c - last), 32'd10);
        last = c;
        n_edge++;
        prev = int'(o_btn[0]);
      end
    end
    chk("af_edges", 32'(n_edge >= 6), 32'd1);
    send(1, 4'd8, 11'h088);
    send(1, 4'd8, 11'h088);
    wait_n(1);
    steady = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (o_btn[0] !== 1'b1) steady = 0;
    end
    chk("af_steady_a", 32'(steady), 32'd1);

    // menu: all reds held 50 cycles
    send(1, 4'd8, 11'h078);
    send(1, 4'd8, 11'h078);
    wait_n(50);
    chk("menu_early", 32'(o_menu), 32'h0);
    wait_n(1);
    chk("menu_on", 32'(o_menu), 32'h1);
    chk("menu_dpad", 32'(o_btn[7:4]), 32'hF);
    send(1, 4'd8, 11'h038);
    send(1, 4'd8, 11'h038);
    wait_n(1);
    chk("menu_release_cycle", 32'(o_menu), 32'h1);
    wait_n(1);
    chk("menu_off", 32'(o_menu), 32'h0);
    chk("menu_dpad_off", 32'(o_btn[7:4]), 32'h0);

    // watchdog: silence for 200 cycles flushes player 0
    send(1, 4'd2, 11'h000);
    send(1, 4'd2, 11'h000);
    wait_n(199);
    chk("wd_before", 32'(o_timeout[0]), 32'h0);
    chk("wd_before_btn", 32'(o_btn[7:0]), 32'h80);
    wait_n(1);
    chk("wd_fire", 32'(o_timeout[0]), 32'h1);
    chk("wd_flush_btn", 32'(o_btn[7:0]), 32'h00);
    send(1, 4'd2, 11'h000);
    chk("wd_clear", 32'(o_timeout[0]), 32'h0);
    send(1, 4'd2, 11'h000);
    wait_n(1);
    chk("wd_rearm_btn", 32'(o_btn[7:0]), 32'h80);

    // report strobed on the terminal cycle: no flush
    send(1, 4'd2, 11'h000);
    wait_n(199);
    report = mk(1, 4'd2, 11'h000, 8'h80, 8'h80);
    valid  = 1'b1;
    @(negedge clk);
    valid  = 1'b0;
    chk("wd_race_timeout", 32'(o_timeout[0]), 32'h0);
    chk("wd_race_btn", 32'(o_btn[7:0]), 32'h80);
    wait_n(2);
    chk("wd_race_btn_later", 32'(o_btn[7:0]), 32'h80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
